// File: rtl/audio_sample_pacer.sv
// Audio sample pacer: buffers irregular 16-bit stereo samples in a small FIFO and
// releases them as 24-bit left-aligned pairs on a fixed-rate strobe for an I2S transmitter.
module audio_sample_pacer #(
    parameter int FIFO_AW  = 3,
    parameter int PREFILL  = 4,
    parameter int PACE_DIV = 512
) (
    input  logic              MCLK_i,
    input  logic              nRST_i,
    input  logic              EN_i,
    input  logic [15:0]       SAMPLE_L_i,
    input  logic [15:0]       SAMPLE_R_i,
    input  logic              SAMPLE_VALID_i,
    output logic [23:0]       PDATA_LEFT_o,
    output logic [23:0]       PDATA_RIGHT_o,
    output logic              PDATA_VALID_o,
    output logic              I2S_EN_o,
    output logic [FIFO_AW:0]  FIFO_LEVEL_o,
    output logic              UNDERFLOW_o,
    output logic              OVERFLOW_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int CW    = (PACE_DIV > 1) ? $clog2(PACE_DIV) : 1;
    localparam logic [CW-1:0]    CNT_MAX     = CW'(PACE_DIV - 1);
    localparam logic [FIFO_AW:0] LVL_FULL    = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0] LVL_PREFILL = (FIFO_AW + 1)'(PREFILL);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PREFILL = 2'd1,
        ST_RUN     = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [FIFO_AW:0]     level_q, level_d;
    logic [15:0]          mem_l_q [DEPTH];
    logic [15:0]          mem_r_q [DEPTH];
    logic [23:0]          pdata_l_q, pdata_l_d, pdata_r_q, pdata_r_d;
    logic                 valid_q, i2s_en_q, i2s_en_d, unf_q, ovf_q;
    logic                 tick_s, flush_s, run_s, full_s;
    logic                 wr_req_s, wr_acc_s, pop_s, unf_s, ovf_s;

    // FIFO control decode; a pop at full frees the slot the concurrent write takes
    always_comb begin
        tick_s   = (cnt_q == CNT_MAX);
        cnt_d    = tick_s ? '0 : cnt_q + CW'(1);
        flush_s  = !EN_i || (state_q == ST_IDLE);
        run_s    = EN_i && (state_q == ST_RUN);
        full_s   = (level_q == LVL_FULL);
        wr_req_s = SAMPLE_VALID_i && !flush_s;
        pop_s    = tick_s && run_s && (level_q != '0);
        unf_s    = tick_s && run_s && (level_q == '0);
        wr_acc_s = wr_req_s && (!full_s || pop_s);
        ovf_s    = wr_req_s && full_s && !pop_s;
    end

    // FIFO pointer and occupancy next state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_s) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (wr_acc_s) wr_ptr_d = wr_ptr_q + FIFO_AW'(1);
            else          wr_ptr_d = wr_ptr_q;
            if (pop_s)    rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
            else          rd_ptr_d = rd_ptr_q;
            case ({wr_acc_s, pop_s})
                2'b10:   level_d = level_q + (FIFO_AW + 1)'(1);
                2'b01:   level_d = level_q - (FIFO_AW + 1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (EN_i) state_d = ST_PREFILL;
                else      state_d = ST_IDLE;
            end
            ST_PREFILL: begin
                if (!EN_i)                       state_d = ST_IDLE;
                else if (level_q >= LVL_PREFILL) state_d = ST_RUN;
                else                             state_d = ST_PREFILL;
            end
            ST_RUN: begin
                if (!EN_i)      state_d = ST_IDLE;
                else if (unf_s) state_d = ST_PREFILL;
                else            state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: data and transmitter enable only change on a pace strobe
    always_comb begin
        pdata_l_d = pdata_l_q;
        pdata_r_d = pdata_r_q;
        i2s_en_d  = i2s_en_q;
        if (tick_s) begin
            case (state_q)
                ST_IDLE: begin
                    pdata_l_d = 24'h000000;
                    pdata_r_d = 24'h000000;
                    i2s_en_d  = 1'b0;
                end
                ST_PREFILL: begin
                    i2s_en_d = 1'b1;
                end
                ST_RUN: begin
                    i2s_en_d = 1'b1;
                    if (pop_s) begin
                        pdata_l_d = {mem_l_q[rd_ptr_q], 8'h00};
                        pdata_r_d = {mem_r_q[rd_ptr_q], 8'h00};
                    end else begin
                        pdata_l_d = pdata_l_q;
                        pdata_r_d = pdata_r_q;
                    end
                end
                default: begin
                    pdata_l_d = 24'h000000;
                    pdata_r_d = 24'h000000;
                    i2s_en_d  = 1'b0;
                end
            endcase
        end else begin
            i2s_en_d = i2s_en_q;
        end
    end

    // Sample storage; contents are don't-care until written
    always_ff @(posedge MCLK_i) begin
        if (wr_acc_s) begin
            mem_l_q[wr_ptr_q] <= SAMPLE_L_i;
            mem_r_q[wr_ptr_q] <= SAMPLE_R_i;
        end
    end

    // State, counter, FIFO bookkeeping and output registers
    always_ff @(posedge MCLK_i or negedge nRST_i) begin
        if (!nRST_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            pdata_l_q <= 24'h000000;
            pdata_r_q <= 24'h000000;
            valid_q   <= 1'b0;
            i2s_en_q  <= 1'b0;
            unf_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            pdata_l_q <= pdata_l_d;
            pdata_r_q <= pdata_r_d;
            valid_q   <= tick_s;
            i2s_en_q  <= i2s_en_d;
            unf_q     <= unf_s;
            ovf_q     <= ovf_s;
        end
    end

    assign PDATA_LEFT_o  = pdata_l_q;
    assign PDATA_RIGHT_o = pdata_r_q;
    assign PDATA_VALID_o = valid_q;
    assign I2S_EN_o      = i2s_en_q;
    assign FIFO_LEVEL_o  = level_q;
    assign UNDERFLOW_o   = unf_q;
    assign OVERFLOW_o    = ovf_q;

endmodule

// File: doc/audio_sample_pacer.md
AUDIO_SAMPLE_PACER -- requirements
Module: audio_sample_pacer

Interface
REQ-001 SHALL have parameter FIFO_AW, default 3, meaning FIFO address width (depth 2^FIFO_AW = 8 sample pairs).
REQ-002 SHALL have parameter PREFILL, default 4, meaning the FIFO level that triggers the move from PREFILL to RUN.
REQ-003 SHALL have parameter PACE_DIV, default 512, meaning MCLK cycles per output strobe (24.576 MHz / 512 = 48 kHz).
REQ-004 Port MCLK_i, input, 1, single clock for all logic; no other clock.
REQ-005 Port nRST_i, input, 1, asynchronous active-low reset.
REQ-006 Port EN_i, input, 1, audio enable.
REQ-007 Port SAMPLE_L_i, input, 16, left sample in signed two's complement.
REQ-008 Port SAMPLE_R_i, input, 16, right sample in signed two's complement.
REQ-009 Port SAMPLE_VALID_i, input, 1, one-cycle strobe qualifying the sample pair; arrival rate is irregular.
REQ-010 Port PDATA_LEFT_o, output, 24, left sample to the I2S transmitter.
REQ-011 Port PDATA_RIGHT_o, output, 24, right sample to the I2S transmitter.
REQ-012 Port PDATA_VALID_o, output, 1, one-cycle strobe to the I2S transmitter.
REQ-013 Port I2S_EN_o, output, 1, transmitter enable; the transmitter samples it on PDATA_VALID_o.
REQ-014 Port FIFO_LEVEL_o, output, FIFO_AW+1, current FIFO occupancy, 0..8.
REQ-015 Port UNDERFLOW_o, output, 1, one-cycle pulse on underflow.
REQ-016 Port OVERFLOW_o, output, 1, one-cycle pulse on overflow.

Function
REQ-017 Input conversion SHALL be {sample[15:0], 8'h00}, left-aligned, with the sign preserved.
REQ-018 Pace counter SHALL free-run from 0 to PACE_DIV-1 and wrap in every state, including IDLE.
REQ-019 PDATA_VALID_o SHALL be high exactly one cycle per wrap, in the cycle after the counter equals PACE_DIV-1.
- PDATA_LEFT_o, PDATA_RIGHT_o and I2S_EN_o are updated in that same registered edge.
REQ-020 State machine SHALL have three states: IDLE, PREFILL and RUN.
REQ-021 IDLE: FIFO flushed, writes ignored; on a strobe the data outputs SHALL be 0 and I2S_EN_o SHALL be 0.
- Transition IDLE->PREFILL when EN_i=1.
REQ-022 PREFILL: writes accepted; strobes SHALL repeat the last output data; I2S_EN_o SHALL be 1.
- Transition PREFILL->RUN when level >= PREFILL.
REQ-023 RUN, each strobe with level > 0: SHALL pop the head pair onto PDATA_* and set I2S_EN_o=1.
REQ-024 RUN, strobe with level = 0: data SHALL repeat the last value, UNDERFLOW_o SHALL pulse with the strobe, and the state SHALL go to PREFILL.
REQ-025 EN_i=0 in any state SHALL go to IDLE on the next edge and flush the FIFO (level 0).
- Pending output data are not cleared until the next strobe, which emits zeros.
REQ-026 Write when level < 8 SHALL store the pair and increment the level one cycle later.
REQ-027 Write when level = 8 with no pop in the same cycle SHALL drop the new pair, leave the FIFO unchanged and pulse OVERFLOW_o one cycle.
REQ-028 Simultaneous write and pop SHALL leave the level unchanged.
- At full, the write is accepted because the pop frees a slot.
- At empty in RUN, underflow applies and the write is stored.
REQ-029 Pointers SHALL wrap modulo 8; level SHALL never exceed 8 or go below 0.
REQ-030 The FIFO_LEVEL_o, UNDERFLOW_o and OVERFLOW_o outputs SHALL all be registered.

Reset
REQ-031 On nRST_i low, asynchronously:
- state IDLE, pace counter 0, pointers 0, level 0;
- PDATA_LEFT_o, PDATA_RIGHT_o = 24'h000000;
- PDATA_VALID_o, I2S_EN_o, UNDERFLOW_o, OVERFLOW_o = 0.
REQ-032 After release, the first PDATA_VALID_o SHALL occur PACE_DIV cycles after the first active edge.
- Reset asserted mid-FIFO discards all stored samples.

Verification
REQ-033 Reset release, EN_i=0, 2048 cycles -> 4 strobes, each with PDATA=0 and I2S_EN_o=0, spaced 512 cycles.
REQ-034 EN_i=1, write pairs L=16'h1234 and R=16'h8001, then 3 more pairs -> RUN entered at level 4.
- Next strobe outputs L=24'h123400 and R=24'h800100.
REQ-035 RUN with level 1, no writes -> first strobe pops the pair; second strobe repeats the same data with UNDERFLOW_o=1 and state PREFILL.
REQ-036 Fill to 8, write again without a pop -> OVERFLOW_o pulse, level stays 8, and the 9th pair is never output.
- Repeat with the write coincident with a strobe -> level stays 8 and the pair is accepted.
REQ-037 RUN at level 5, drop EN_i -> next edge gives level 0 and IDLE; next strobe gives PDATA=0 and I2S_EN_o=0.
REQ-038 Assert nRST_i mid-run at level 6 -> all outputs go to reset values immediately, without a clock edge.
